// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multicycle control FSM and the datapath.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       alu_done;
  logic [2:0] op_a;
  logic [5:0] alu_func;
  logic       alu_start;
  logic       alu_src;
  logic       reg_dst;
  logic       reg_we;
  logic       mem_to_reg;
  logic       mem_re;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       pc_src;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready, alu_done,
    output op_a, alu_func, alu_start, alu_src, reg_dst, reg_we, mem_to_reg,
           mem_re, mem_we, ir_we, pc_we, pc_src, fault, state
  );

  modport slave (
    output op, funct, zero, mem_ready, alu_done,
    input  op_a, alu_func, alu_start, alu_src, reg_dst, reg_we, mem_to_reg,
           mem_re, mem_we, ir_we, pc_we, pc_src, fault, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset main control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing
// with bounded waits on memory and the iterative MULT/DIV unit.
module multicycle_ctrl_fsm #(
  parameter logic [2:0] OPA_EXEC = 3'b010,
  parameter int         WAIT_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_ctrl_fsm_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_MD  = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_WB       = 4'd10,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  state_t     w_next;
  logic [7:0] w_cnt_next;
  logic       w_limit;
  logic       w_wait_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_limit      = (r_cnt == CNT_LAST);
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_EXEC_MD) ||
                        (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    bus.op_a       = 3'b000;
    bus.alu_func   = 6'b000000;
    bus.alu_start  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.fault      = 1'b0;
    bus.state      = r_state;

    case (r_state)
      S_FETCH: begin
        bus.mem_re = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          w_next    = S_DECODE;
        end else if (w_limit) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE: w_next = (bus.funct == 6'b011000 || bus.funct == 6'b011010)
                             ? S_EXEC_MD : S_EXEC_R;
          6'b001000, 6'b001010, 6'b001100, 6'b001101: w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_next = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        bus.op_a     = OPA_EXEC;
        bus.alu_func = bus.funct;
        w_next       = S_WB;
      end
      S_EXEC_MD: begin
        bus.op_a      = OPA_EXEC;
        bus.alu_func  = bus.funct;
        // Counter is zero only on the first cycle of the visit.
        bus.alu_start = (r_cnt == 8'd0);
        if (bus.alu_done)  w_next = S_WB;
        else if (w_limit)  w_next = S_FAULT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        bus.op_a     = OPA_EXEC;
        bus.alu_func = bus.op;
        bus.alu_src  = 1'b1;
        if (r_state == S_EXEC_I)   w_next = S_WB;
        else if (bus.op == OP_LW)  w_next = S_MEM_RD;
        else                       w_next = S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_re = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
        else if (w_limit)  w_next = S_FAULT;
      end
      S_MEM_WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_we = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
        else if (w_limit)  w_next = S_FAULT;
      end
      S_BRANCH: begin
        bus.op_a     = OPA_EXEC;
        bus.alu_func = OP_BEQ;
        bus.pc_we    = bus.zero;
        bus.pc_src   = bus.zero;
        w_next       = S_FETCH;
      end
      S_WB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = (bus.op == OP_RTYPE);
        w_next      = S_FETCH;
      end
      S_FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
        w_next = S_FAULT;
      end
    endcase

    // Wait counter restarts on every state change and counts idle cycles in wait states.
    if (w_next != r_state)
      w_cnt_next = 8'd0;
    else if (w_wait_state)
      w_cnt_next = r_cnt + 8'd1;
  end

endmodule
